// File: rtl/set_bit_walker_pkg.sv
// rtl/set_bit_walker_pkg.sv - shared types and helpers for the set-bit walker
package set_bit_walker_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WALK = 1'b1
    } walk_state_t;

    function automatic int idx_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/tz_count.sv
// rtl/tz_count.sv - combinational trailing-zero counter; all-zero input yields DATA_WIDTH
module tz_count #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]         din,
    output logic [$clog2(DATA_WIDTH):0]   dout
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;

    // Scan from MSB down so the lowest set bit is the last (winning) assignment.
    always_comb begin
        dout = CW'(DATA_WIDTH);
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (din[i]) begin
                dout = CW'(i);
            end
        end
    end

endmodule

// File: rtl/set_bit_walker.sv
// rtl/set_bit_walker.sv - walks the set bits of a word LSB-first, one index per beat
module set_bit_walker
    import set_bit_walker_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int IDX_W      = idx_w(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_last,
    output logic                  done
);

    walk_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  done_q, done_d;

    logic [IDX_W:0]        tz_cnt;
    logic [DATA_WIDTH-1:0] word_low_clr;
    logic                  unused_tz_msb;

    tz_count #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tz_count (
        .din  (word_q),
        .dout (tz_cnt)
    );

    // word_q is non-zero whenever WALK is active, so the counter MSB never matters.
    assign unused_tz_msb = tz_cnt[IDX_W];
    assign word_low_clr  = word_q & (word_q - DATA_WIDTH'(1));

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == WALK);
    assign out_idx   = tz_cnt[IDX_W-1:0];
    assign out_last  = (state_q == WALK) && (word_low_clr == '0);
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (din != '0) begin
                        word_d  = din;
                        state_d = WALK;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            WALK: begin
                if (out_ready) begin
                    word_d = word_low_clr;
                    if (out_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            done_q  <= done_d;
        end
    end

endmodule
